// File: rtl/updown_counter_param.sv
// Up/down counter over 0..LIMIT with programmable step, sync clear/load, and wrap or saturate.
// One-cycle latency on q/tc/ovf, match is combinational; no backpressure, acts every enabled edge.
module updown_counter_param #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] LIMIT    = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             match
);

    localparam logic [WIDTH:0]   LIMIT_X = {1'b0, LIMIT};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_r, q_nxt;
    logic             tc_r, tc_nxt;
    logic             ovf_r, ovf_nxt;
    logic [WIDTH:0]   sum_up;

    always_comb begin
        q_nxt   = q_r;
        tc_nxt  = 1'b0;
        ovf_nxt = ovf_r;
        sum_up  = {1'b0, q_r} + {1'b0, step};

        if (clear) begin
            q_nxt   = '0;
            ovf_nxt = 1'b0;
        end else if (load) begin
            q_nxt = (data > LIMIT) ? LIMIT : data;
        end else if (en) begin
            if (mode) begin
                if (sum_up > LIMIT_X) begin
                    tc_nxt  = 1'b1;
                    ovf_nxt = 1'b1;
                    // The wrapped result always fits in WIDTH bits, so modular arithmetic is exact.
                    if (SATURATE) q_nxt = LIMIT;
                    else          q_nxt = q_r + step - LIMIT - ONE;
                end else begin
                    q_nxt = sum_up[WIDTH-1:0];
                end
            end else begin
                if (step > q_r) begin
                    tc_nxt  = 1'b1;
                    ovf_nxt = 1'b1;
                    if (SATURATE) q_nxt = '0;
                    else          q_nxt = q_r + LIMIT + ONE - step;
                end else begin
                    q_nxt = q_r - step;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r   <= '0;
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            q_r   <= q_nxt;
            tc_r  <= tc_nxt;
            ovf_r <= ovf_nxt;
        end
    end

    assign q     = q_r;
    assign tc    = tc_r;
    assign ovf   = ovf_r;
    assign match = (q_r == cmp);

    // Steps larger than the range are not supported when counting.
    step_in_range: assert property (@(posedge clk) disable iff (reset)
        (en && !clear && !load) |-> (step <= LIMIT));

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: two instances (wrap / saturate, WIDTH=4, LIMIT=9) on shared inputs.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0, load = 1'b0, en = 1'b0, mode = 1'b0;
    logic [3:0] data = '0, step = '0, cmp = '0;

    logic [3:0] q_w, q_s;
    logic       tc_w, tc_s, ovf_w, ovf_s, match_w, match_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       sel;
        logic [3:0] q;
        logic       tc;
        logic       ovf;
        logic       mt;
        string      nm;
    } exp_t;

    exp_t sb[$];

    updown_counter_param #(.WIDTH(4), .LIMIT(4'd9), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .data(data),
        .en(en), .mode(mode), .step(step), .cmp(cmp),
        .q(q_w), .tc(tc_w), .ovf(ovf_w), .match(match_w)
    );

    updown_counter_param #(.WIDTH(4), .LIMIT(4'd9), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .data(data),
        .en(en), .mode(mode), .step(step), .cmp(cmp),
        .q(q_s), .tc(tc_s), .ovf(ovf_s), .match(match_s)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per clock edge (or per async reset pulse).
    initial begin
        exp_t       e;
        logic [3:0] aq;
        logic       atc, aovf, amt;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                aq   = e.sel ? q_s     : q_w;
                atc  = e.sel ? tc_s    : tc_w;
                aovf = e.sel ? ovf_s   : ovf_w;
                amt  = e.sel ? match_s : match_w;
                checks++;
                if (aq !== e.q || atc !== e.tc || aovf !== e.ovf || amt !== e.mt) begin
                    errors++;
                    $display("FAIL %s: got q=%0d tc=%0b ovf=%0b match=%0b, want q=%0d tc=%0b ovf=%0b match=%0b",
                             e.nm, aq, atc, aovf, amt, e.q, e.tc, e.ovf, e.mt);
                end
            end
        end
    end

    task automatic cyc(input logic c, input logic l, input logic [3:0] d,
                       input logic e, input logic m, input logic [3:0] s, input logic [3:0] cv,
                       input logic sel, input logic [3:0] eq, input logic etc,
                       input logic eovf, input logic emt, input string nm);
        exp_t x;
        @(negedge clk);
        clear = c; load = l; data = d; en = e; mode = m; step = s; cmp = cv;
        x.sel = sel; x.q = eq; x.tc = etc; x.ovf = eovf; x.mt = emt; x.nm = nm;
        sb.push_back(x);
    endtask

    task automatic reset_pulse(input logic [3:0] emt_q, input logic emt, input string nm);
        exp_t x;
        @(negedge clk);
        x.sel = 1'b0; x.q = emt_q; x.tc = 1'b0; x.ovf = 1'b0; x.mt = emt; x.nm = nm;
        sb.push_back(x);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        //   c  l  d  e  m  s  cmp  sel q  tc ovf mt
        cyc(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, "reset_hold");
        @(posedge clk);
        #2 reset = 1'b0;

        // decade wrap up
        cyc(0, 1, 8, 0, 0, 0, 0,   0, 8, 0, 0, 0, "load8");
        cyc(0, 0, 0, 1, 1, 1, 0,   0, 9, 0, 0, 0, "up_to_9");
        cyc(0, 0, 0, 1, 1, 1, 0,   0, 0, 1, 1, 1, "wrap_9_to_0");
        cyc(0, 0, 0, 1, 1, 1, 0,   0, 1, 0, 1, 0, "after_wrap");

        // compare and hold
        cyc(0, 1, 3, 0, 0, 0, 5,   0, 3, 0, 1, 0, "load3_ovf_kept");
        cyc(0, 0, 0, 1, 1, 1, 5,   0, 4, 0, 1, 0, "up4");
        cyc(0, 0, 0, 1, 1, 1, 5,   0, 5, 0, 1, 1, "match5");
        cyc(0, 0, 0, 0, 1, 1, 5,   0, 5, 0, 1, 1, "hold_en0");
        cyc(0, 0, 0, 1, 1, 0, 5,   0, 5, 0, 1, 1, "hold_step0");
        cyc(0, 0, 0, 1, 1, 1, 5,   0, 6, 0, 1, 0, "up6");

        // async reset mid-count
        reset_pulse(0, 0, "reset_mid_count");

        // step wrap down, LIMIT=9 step=3
        cyc(0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, "load1");
        cyc(0, 0, 0, 1, 0, 3, 0,   0, 8, 1, 1, 0, "down_wrap_1_to_8");
        cyc(0, 0, 0, 1, 0, 3, 0,   0, 5, 0, 1, 0, "down5");
        cyc(0, 0, 0, 1, 0, 3, 0,   0, 2, 0, 1, 0, "down2");
        cyc(0, 0, 0, 1, 0, 3, 0,   0, 9, 1, 1, 0, "down_wrap_2_to_9");

        // saturating instance
        cyc(1, 0, 0, 0, 0, 0, 9,   1, 0, 0, 0, 0, "sat_clear");
        cyc(0, 1, 7, 0, 0, 0, 9,   1, 7, 0, 0, 0, "sat_load7");
        cyc(0, 0, 0, 1, 1, 4, 9,   1, 9, 1, 1, 1, "sat_clamp_hi");
        cyc(0, 0, 0, 1, 1, 4, 9,   1, 9, 1, 1, 1, "sat_hold_hi_1");
        cyc(0, 0, 0, 1, 1, 4, 9,   1, 9, 1, 1, 1, "sat_hold_hi_2");
        cyc(0, 0, 0, 1, 0, 4, 9,   1, 5, 0, 1, 0, "sat_down5");
        cyc(0, 0, 0, 1, 0, 4, 9,   1, 1, 0, 1, 0, "sat_down1");
        cyc(0, 0, 0, 1, 0, 4, 9,   1, 0, 1, 1, 0, "sat_clamp_lo");

        // priority and load clamp (wrap instance q=7 ovf=1 here)
        cyc(0, 1, 12, 1, 1, 1, 9,  0, 9, 0, 1, 1, "load_clamp_over_en");
        cyc(0, 1, 15, 0, 0, 0, 9,  1, 9, 0, 1, 1, "sat_load_clamp");
        cyc(1, 1, 4, 1, 1, 1, 9,   0, 0, 0, 0, 0, "clear_over_load");
        cyc(0, 1, 9, 0, 0, 0, 9,   0, 9, 0, 0, 1, "load_limit");
        cyc(0, 0, 0, 0, 0, 0, 9,   0, 9, 0, 0, 1, "idle");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
